// File: rtl/hram_fair_scheduler_pkg.sv
// Shared types and helpers for the HyperRAM fair scheduler.
package hram_fair_scheduler_pkg;

  // Transaction life cycle: pick a winner, wait for the controller, one quiet cycle.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Ceiling log2 with a floor of one bit, so single-entry fields keep a real width.
  function automatic int clog2_min1(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/hram_pick_winner.sv
// Combinational priority pick: lowest-index urgent requester, else lowest-index requester.
module hram_pick_winner #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  urgent,
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic found_urgent;

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    idx          = '0;
    found_urgent = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (urgent[i]) begin
        idx          = IW'(i);
        found_urgent = 1'b1;
      end
    end
    if (!found_urgent) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) idx = IW'(i);
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/hram_fair_scheduler.sv
// Arbitrates single-beat HyperRAM transactions from several masters onto one
// req/ack port: fixed priority, with starvation counters that promote a
// long-waiting master to urgent.
module hram_fair_scheduler
  import hram_fair_scheduler_pkg::*;
#(
  parameter int masters  = 2,
  parameter int abits    = 24,
  parameter int dbits    = 8,
  parameter int max_wait = 4,
  localparam int GW      = clog2_min1(masters)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [masters-1:0]       m_req,
  output logic [masters-1:0]       m_ack,
  input  logic [masters-1:0]       m_we,
  input  logic [masters*abits-1:0] m_a,
  input  logic [masters*dbits-1:0] m_d,
  output logic [masters*dbits-1:0] m_q,
  output logic                     s_req,
  input  logic                     s_ack,
  output logic                     s_we,
  output logic [abits-1:0]         s_a,
  output logic [dbits-1:0]         s_d,
  input  logic [dbits-1:0]         s_q,
  output logic [GW-1:0]            grant,
  output logic                     busy
);

  localparam int CW = clog2_min1(max_wait + 1);
  localparam logic [CW-1:0] MAX_W = CW'(max_wait);

  state_e                   state_q, state_d;
  logic                     s_req_q, s_req_d;
  logic                     s_we_q, s_we_d;
  logic [abits-1:0]         s_a_q, s_a_d;
  logic [dbits-1:0]         s_d_q, s_d_d;
  logic [masters-1:0]       m_ack_q, m_ack_d;
  logic [masters*dbits-1:0] m_q_q, m_q_d;
  logic [GW-1:0]            grant_q, grant_d;
  logic [CW-1:0]            wait_q [masters];
  logic [CW-1:0]            wait_d [masters];

  logic [masters-1:0]       urgent;
  logic [GW-1:0]            pick_idx;
  logic                     pick_valid;

  // A master is urgent once it has watched max_wait grants go elsewhere.
  always_comb begin
    for (int i = 0; i < masters; i++) begin
      urgent[i] = (max_wait != 0) && m_req[i] && (wait_q[i] == MAX_W);
    end
  end

  hram_pick_winner #(
    .N  (masters),
    .IW (GW)
  ) u_pick (
    .urgent (urgent),
    .req    (m_req),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Next-state and next-output logic for the grant/issue/release sequence.
  always_comb begin
    state_d = state_q;
    s_req_d = s_req_q;
    s_we_d  = s_we_q;
    s_a_d   = s_a_q;
    s_d_d   = s_d_q;
    m_ack_d = '0;
    m_q_d   = m_q_q;
    grant_d = grant_q;
    for (int i = 0; i < masters; i++) wait_d[i] = wait_q[i];

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          s_a_d   = m_a[int'(pick_idx)*abits +: abits];
          s_d_d   = m_d[int'(pick_idx)*dbits +: dbits];
          s_we_d  = m_we[pick_idx];
          s_req_d = 1'b1;
          grant_d = pick_idx;
          state_d = ST_ISSUE;
          // Winner restarts its count; waiting losers age; idle masters forget.
          for (int i = 0; i < masters; i++) begin
            if (GW'(i) == pick_idx)   wait_d[i] = '0;
            else if (!m_req[i])       wait_d[i] = '0;
            else if (wait_q[i] == MAX_W) wait_d[i] = MAX_W;
            else                      wait_d[i] = wait_q[i] + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (s_ack) begin
          s_req_d          = 1'b0;
          m_ack_d[grant_q] = 1'b1;
          m_q_d            = {masters{s_q}};
          state_d          = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Gives the requester one cycle to drop m_req before we sample again.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; controller shares this reset, so abort is clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_req_q <= 1'b0;
      s_we_q  <= 1'b0;
      s_a_q   <= '0;
      s_d_q   <= '0;
      m_ack_q <= '0;
      m_q_q   <= '0;
      grant_q <= '0;
      // NOTE: the wait counters are a few flops, not RAM, so resetting them is cheap and required.
      for (int i = 0; i < masters; i++) wait_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      s_req_q <= s_req_d;
      s_we_q  <= s_we_d;
      s_a_q   <= s_a_d;
      s_d_q   <= s_d_d;
      m_ack_q <= m_ack_d;
      m_q_q   <= m_q_d;
      grant_q <= grant_d;
      for (int i = 0; i < masters; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign s_req = s_req_q;
  assign s_we  = s_we_q;
  assign s_a   = s_a_q;
  assign s_d   = s_d_q;
  assign m_ack = m_ack_q;
  assign m_q   = m_q_q;
  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hram_fair_scheduler.sv
// Directed bench: two schedulers in lockstep on shared inputs, one with
// max_wait=4 and one with max_wait=0 (pure fixed priority).
module tb_hram_fair_scheduler;

  localparam int M  = 2;
  localparam int AB = 24;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [M-1:0]  m_req;
  logic [M-1:0]  m_we;
  logic [M*AB-1:0] m_a;
  logic [M*DB-1:0] m_d;
  logic          s_ack;
  logic [DB-1:0] s_q;

  logic [M-1:0]    m_ack,  m_ack0;
  logic [M*DB-1:0] m_q,    m_q0;
  logic            s_req,  s_req0;
  logic            s_we,   s_we0;
  logic [AB-1:0]   s_a,    s_a0;
  logic [DB-1:0]   s_d,    s_d0;
  logic [0:0]      grant,  grant0;
  logic            busy,   busy0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hram_fair_scheduler #(.masters(M), .abits(AB), .dbits(DB), .max_wait(4)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_ack(m_ack), .m_we(m_we),
    .m_a(m_a), .m_d(m_d), .m_q(m_q), .s_req(s_req), .s_ack(s_ack),
    .s_we(s_we), .s_a(s_a), .s_d(s_d), .s_q(s_q), .grant(grant), .busy(busy)
  );

  hram_fair_scheduler #(.masters(M), .abits(AB), .dbits(DB), .max_wait(0)) dut0 (
    .clk(clk), .reset(reset), .m_req(m_req), .m_ack(m_ack0), .m_we(m_we),
    .m_a(m_a), .m_d(m_d), .m_q(m_q0), .s_req(s_req0), .s_ack(s_ack),
    .s_we(s_we0), .s_a(s_a0), .s_d(s_d0), .s_q(s_q), .grant(grant0), .busy(busy0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_g;
    reset = 1'b1; m_req = '0; m_we = '0; m_a = '0; m_d = '0; s_ack = 1'b0; s_q = '0;
    tick(); tick();
    check("rst_s_req", s_req, 1'b0);
    check("rst_m_ack", m_ack, 2'b00);
    check("rst_m_q",   m_q,   16'h0);
    check("rst_grant", grant, 1'b0);
    check("rst_busy",  busy,  1'b0);
    check("rst_s_a",   s_a,   24'h0);
    check("rst_s_we",  s_we,  1'b0);
    reset = 1'b0;
    tick();

    // Single write from master 1.
    m_req = 2'b10; m_we = 2'b10;
    m_a   = {24'h123456, 24'h000000};
    m_d   = {8'hA5, 8'h00};
    check("wr_s_req_before_edge", s_req, 1'b0);
    tick();
    check("wr_s_req",  s_req, 1'b1);
    check("wr_s_a",    s_a,   24'h123456);
    check("wr_s_d",    s_d,   8'hA5);
    check("wr_s_we",   s_we,  1'b1);
    check("wr_grant",  grant, 1'b1);
    check("wr_busy",   busy,  1'b1);
    tick();
    check("wr_hold_s_req", s_req, 1'b1);
    check("wr_hold_s_a",   s_a,   24'h123456);
    check("wr_no_ack_yet", m_ack, 2'b00);
    s_ack = 1'b1; s_q = 8'h00;
    tick();
    check("wr_m_ack",     m_ack, 2'b10);
    check("wr_s_req_off", s_req, 1'b0);
    check("wr_busy_rel",  busy,  1'b1);
    m_req = 2'b00; s_ack = 1'b0;
    tick();
    check("wr_m_ack_one_cycle", m_ack, 2'b00);
    check("wr_busy_low",        busy,  1'b0);

    // Single read from master 0.
    m_req = 2'b01; m_we = 2'b00;
    m_a   = {24'h000000, 24'h00ABCD};
    tick();
    check("rd_s_we",  s_we,  1'b0);
    check("rd_s_a",   s_a,   24'h00ABCD);
    check("rd_grant", grant, 1'b0);
    s_ack = 1'b1; s_q = 8'h3C;
    tick();
    check("rd_m_ack",   m_ack,    2'b01);
    check("rd_m_q_slot", m_q[7:0], 8'h3C);
    check("rd_m_q_all", m_q,      16'h3C3C);
    m_req = 2'b00; s_ack = 1'b0;
    tick();
    check("rd_m_ack_off", m_ack, 2'b00);

    // Both masters request continuously: starvation pattern 0,0,0,0,1 repeating.
    m_req = 2'b11; m_we = 2'b00;
    m_a   = {24'h111111, 24'h222222};
    for (int t = 0; t < 20; t++) begin
      exp_g = (t % 5 == 4);
      tick();
      check($sformatf("fair_grant_%0d", t),   grant,  exp_g);
      check($sformatf("fair_s_a_%0d", t),     s_a,    exp_g ? 24'h111111 : 24'h222222);
      check($sformatf("fixed_grant_%0d", t),  grant0, 1'b0);
      s_ack = 1'b1; s_q = 8'h5A;
      tick();
      check($sformatf("fair_ack_%0d", t),  m_ack,  exp_g ? 2'b10 : 2'b01);
      check($sformatf("fixed_ack_%0d", t), m_ack0, 2'b01);
      s_ack = 1'b0;
      tick();
    end
    m_req = 2'b00;
    tick();

    // Asynchronous reset while waiting in ISSUE.
    m_req = 2'b01;
    tick();
    check("rst_mid_s_req_pre", s_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_s_req", s_req, 1'b0);
    check("rst_mid_busy",  busy,  1'b0);
    check("rst_mid_m_ack", m_ack, 2'b00);
    check("rst_mid_m_q",   m_q,   16'h0);
    m_req = 2'b00;
    #2 reset = 1'b0;
    tick();
    tick();
    check("rst_after_m_ack", m_ack, 2'b00);
    check("rst_after_busy",  busy,  1'b0);
    check("rst_after_s_req", s_req, 1'b0);

    // Stray s_ack while idle.
    s_ack = 1'b1; s_q = 8'hFF;
    tick();
    check("stray_idle_m_ack", m_ack, 2'b00);
    check("stray_idle_busy",  busy,  1'b0);
    check("stray_idle_m_q",   m_q,   16'h0);
    s_ack = 1'b0;

    // s_ack held into RELEASE must not produce a second ack.
    m_req = 2'b10;
    tick();
    s_ack = 1'b1; s_q = 8'h77;
    tick();
    check("stray_rel_first_ack", m_ack, 2'b10);
    m_req = 2'b00;
    tick();
    check("stray_rel_m_ack", m_ack, 2'b00);
    check("stray_rel_busy",  busy,  1'b0);
    check("stray_rel_s_req", s_req, 1'b0);
    s_ack = 1'b0;
    tick();
    check("stray_rel_idle_ack", m_ack, 2'b00);
    check("stray_rel_m_q",      m_q,   16'h7777);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hram_fair_scheduler.md
Name: hram_fair_scheduler

Overview:
Schedules single-beat HyperRAM transactions from several requesters (DMA engine, MMC64 RAM port, future masters) onto the one req/ack port of the hyperram controller. Fixed priority (index 0 highest) with a per-master starvation counter that promotes a waiting master to urgent. Sits between the requesters and hyperram, in the sysclk domain.

Parameters:
masters, 2, number of requesting ports (1..8)
abits, 24, address width
dbits, 8, data width
max_wait, 4, grants to other masters before a waiting master becomes urgent; 0 = pure fixed priority

Ports:
clk  in  1  system clock (sysclk)
reset  in  1  asynchronous, active-high reset
m_req  in  masters  per-master request level
m_ack  out  masters  per-master one-cycle completion pulse
m_we  in  masters  per-master write enable
m_a  in  masters*abits  packed addresses, master i at [i*abits +: abits]
m_d  in  masters*dbits  packed write data
m_q  out  masters*dbits  packed read data, broadcast copy of latched s_q
s_req  out  1  request to hyperram
s_ack  in  1  completion pulse from hyperram
s_we  out  1  write enable to hyperram
s_a  out  abits  address to hyperram
s_d  out  dbits  write data to hyperram
s_q  in  dbits  read data from hyperram, valid with s_ack
grant  out  clog2(masters) (min 1)  index of current/last granted master
busy  out  1  high while state != IDLE

Behaviour:
- Clock/reset: one clock (clk); reset asynchronous, active-high. Reset values: s_req=0, s_we=0, s_a=0, s_d=0, m_ack=0, m_q=0, grant=0, busy=0, all wait counters 0, state IDLE.
- States: IDLE -> ISSUE -> RELEASE -> IDLE.
- IDLE: if any m_req set, pick winner: lowest-index urgent requester if any is urgent, else lowest-index requester. Register s_a/s_d/s_we from winner, s_req<=1, grant<=winner, -> ISSUE. Latency: m_req high at edge N gives s_req high after edge N.
- Urgent: wait counter of master i == max_wait and m_req[i]=1. Never urgent when max_wait=0.
- ISSUE: hold s_req and outputs stable. On s_ack: s_req<=0, m_ack[grant]<=1, m_q<=s_q replicated to all slots (write: s_q ignored by requester), -> RELEASE. Ack latency: s_ack at edge M gives m_ack after edge M. No timeout; waits indefinitely.
- RELEASE (one cycle): m_ack<=0; requests not sampled; -> IDLE. Requester drops m_req in the cycle m_ack is high. If m_req is still high at the next IDLE edge, it is a new back-to-back request.
- Wait counters, updated at each grant in IDLE: winner's counter <=0; each other master with m_req high increments, saturating at max_wait; masters with m_req low are cleared.
- Requester must hold m_we/m_a/m_d stable while m_req is high; the scheduler samples them only in IDLE.
- Simultaneous: several urgent masters, lowest index wins, the others keep saturated counters. s_ack outside ISSUE is ignored.
- Reset mid-transaction: everything returns to reset values immediately; hyperram shares the reset, so no dangling transaction.
- Counter width: clog2(max_wait+1), minimum 1 bit.

Decomposition:
- Shared package: state encoding (IDLE/ISSUE/RELEASE), clog2 helper function.
- One natural sub-module: hram_pick_winner, combinational priority pick over {urgent vector, req vector}, returning index and valid. Instantiated once.

Test Plan:
- Single master 1 write, a=0x123456, d=0xA5 -> s_req the cycle after m_req with s_a=0x123456, s_d=0xA5, s_we=1; s_ack -> m_ack[1] one cycle later for exactly one cycle; busy low two cycles after s_ack.
- Read with s_q=0x3C on s_ack -> m_q slot of the granted master = 0x3C while m_ack is high.
- Both req together, max_wait=4, master 0 back-to-back -> grants 0,0,0,0,1; master 1 counter reaches 4, wins, then clears.
- max_wait=0, master 0 always requesting -> master 1 never granted over 20 transactions.
- Reset asserted while in ISSUE -> s_req, m_ack, busy go 0 immediately without a clock edge; after release, idle with no spurious ack.
- Stray s_ack in IDLE/RELEASE -> no m_ack, state unchanged.
